// File: rtl/overlap_window_addr_ctrl.sv
// Address controller for a circular sample RAM feeding overlapped analysis windows.
// Storage is released one hop at a time, only once a window has been fully read.
module overlap_window_addr_ctrl #(
    parameter int ADDRWIDTH   = 12,
    parameter int WINWIDTH    = 11,
    parameter int LOG_OVERLAP = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enqueue,
    input  logic                 dequeue,
    output logic                 full,
    output logic                 empty,
    output logic [ADDRWIDTH-1:0] read_addr,
    output logic [ADDRWIDTH-1:0] write_addr,
    output logic [WINWIDTH-1:0]  window_addr,
    output logic                 win_first,
    output logic                 win_last,
    output logic [ADDRWIDTH:0]   level,
    output logic [15:0]          window_count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int PW = ADDRWIDTH + 1;
    localparam logic [PW-1:0]       HOP_P    = PW'((1 << WINWIDTH) >> LOG_OVERLAP);
    localparam logic [PW-1:0]       DEPTH_P  = {1'b1, {ADDRWIDTH{1'b0}}};
    localparam logic [WINWIDTH-1:0] WIN_LAST = {WINWIDTH{1'b1}};

    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       base_ptr;
    logic [WINWIDTH-1:0] offset;
    logic                enq_fire;
    logic                deq_fire;

    // All status is derived from registered state so enqueue and dequeue are
    // judged against the same pre-cycle view of the buffer.
    assign level       = wr_ptr - base_ptr;
    assign full        = (level == DEPTH_P);
    assign empty       = (level <= {{(PW-WINWIDTH){1'b0}}, offset});
    assign write_addr  = wr_ptr[ADDRWIDTH-1:0];
    assign read_addr   = base_ptr[ADDRWIDTH-1:0] + ADDRWIDTH'(offset);
    assign window_addr = offset;
    assign win_first   = (offset == '0);
    assign win_last    = (offset == WIN_LAST);

    assign enq_fire = enqueue && !full;
    assign deq_fire = dequeue && !empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr       <= '0;
            base_ptr     <= '0;
            offset       <= '0;
            window_count <= '0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            overflow  <= enqueue && full;
            underflow <= dequeue && empty;
            if (enq_fire) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (deq_fire) begin
                // Finishing a window frees exactly one hop of the oldest samples.
                if (offset == WIN_LAST) begin
                    offset       <= '0;
                    base_ptr     <= base_ptr + HOP_P;
                    window_count <= window_count + 16'd1;
                end else begin
                    offset <= offset + WINWIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_overlap_window_addr_ctrl.sv
// Bench for overlap_window_addr_ctrl: vector table, directed corner sequences,
// and random traffic compared against an unbounded-integer reference model.
module tb_overlap_window_addr_ctrl;

    localparam int AW = 4;
    localparam int WW = 3;
    localparam int LO = 1;
    localparam int DEPTH = 16;
    localparam int WIN = 8;
    localparam int HOP = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enqueue = 1'b0;
    logic          dequeue = 1'b0;
    logic          full;
    logic          empty;
    logic [AW-1:0] read_addr;
    logic [AW-1:0] write_addr;
    logic [WW-1:0] window_addr;
    logic          win_first;
    logic          win_last;
    logic [AW:0]   level;
    logic [15:0]   window_count;
    logic          overflow;
    logic          underflow;

    overlap_window_addr_ctrl #(.ADDRWIDTH(AW), .WINWIDTH(WW), .LOG_OVERLAP(LO)) dut (
        .clock(clock), .reset(reset), .enqueue(enqueue), .dequeue(dequeue),
        .full(full), .empty(empty), .read_addr(read_addr), .write_addr(write_addr),
        .window_addr(window_addr), .win_first(win_first), .win_last(win_last),
        .level(level), .window_count(window_count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: samples written and oldest retained sample as plain counts.
    int m_wr = 0, m_base = 0, m_off = 0, m_wc = 0;
    bit m_ovf = 0, m_unf = 0;
    bit last_deq_fire;
    int last_rd;

    typedef struct {
        bit e, d, r;
        int lvl, rd, wr, wa;
        bit emp, ful, ovf, unf;
        int wc;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input int exp);
        n_checks++;
        if (got !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_model();
        int lvl;
        lvl = m_wr - m_base;
        chk("level", 32'(level), lvl);
        chk("full", 32'(full), int'(lvl == DEPTH));
        chk("empty", 32'(empty), int'(lvl <= m_off));
        chk("read_addr", 32'(read_addr), (m_base + m_off) % DEPTH);
        chk("write_addr", 32'(write_addr), m_wr % DEPTH);
        chk("window_addr", 32'(window_addr), m_off);
        chk("win_first", 32'(win_first), int'(m_off == 0));
        chk("win_last", 32'(win_last), int'(m_off == WIN - 1));
        chk("window_count", 32'(window_count), m_wc);
        chk("overflow", 32'(overflow), int'(m_ovf));
        chk("underflow", 32'(underflow), int'(m_unf));
    endtask

    task automatic cycle(input bit e, input bit d, input bit r);
        int lvl;
        bit is_full, is_empty;
        @(negedge clock);
        enqueue = e;
        dequeue = d;
        reset = r;
        lvl = m_wr - m_base;
        is_full = (lvl == DEPTH);
        is_empty = (lvl <= m_off);
        last_rd = int'(read_addr);
        last_deq_fire = !r && d && !is_empty;
        @(posedge clock);
        if (r) begin
            m_wr = 0; m_base = 0; m_off = 0; m_wc = 0; m_ovf = 0; m_unf = 0;
        end else begin
            m_ovf = e && is_full;
            m_unf = d && is_empty;
            if (e && !is_full) m_wr++;
            if (d && !is_empty) begin
                m_off++;
                if (m_off == WIN) begin
                    m_off = 0;
                    m_base += HOP;
                    m_wc = (m_wc + 1) % 65536;
                end
            end
        end
        #1;
        check_model();
    endtask

    function automatic void add(input bit e, d, r, input int lvl, rd, wr, wa,
                                input bit emp, ful, ovf, unf, input int wc);
        vec_t v;
        v.e = e; v.d = d; v.r = r; v.lvl = lvl; v.rd = rd; v.wr = wr; v.wa = wa;
        v.emp = emp; v.ful = ful; v.ovf = ovf; v.unf = unf; v.wc = wc;
        vecs.push_back(v);
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset + idle, then one full window of writes and reads.
        add(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) add(1, 0, 0, i + 1, 0, i + 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) add(0, 1, 0, 8, i + 1, 8, i + 1, 0, 0, 0, 0, 0);
        add(0, 1, 0, 4, 4, 8, 0, 0, 0, 0, 0, 1);
        // Short fill followed by an over-read.
        add(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(1, 0, 0, i + 1, 0, i + 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 1, 0, 3, i + 1, 3, i + 1, i == 2, 0, 0, 0, 0);
        add(0, 1, 0, 3, 3, 3, 3, 1, 0, 0, 1, 0);
        add(0, 0, 0, 3, 3, 3, 3, 1, 0, 0, 0, 0);

        foreach (vecs[n]) begin
            cycle(vecs[n].e, vecs[n].d, vecs[n].r);
            chk("tbl_level", 32'(level), vecs[n].lvl);
            chk("tbl_read_addr", 32'(read_addr), vecs[n].rd);
            chk("tbl_write_addr", 32'(write_addr), vecs[n].wr);
            chk("tbl_window_addr", 32'(window_addr), vecs[n].wa);
            chk("tbl_empty", 32'(empty), int'(vecs[n].emp));
            chk("tbl_full", 32'(full), int'(vecs[n].ful));
            chk("tbl_overflow", 32'(overflow), int'(vecs[n].ovf));
            chk("tbl_underflow", 32'(underflow), int'(vecs[n].unf));
            chk("tbl_window_count", 32'(window_count), vecs[n].wc);
        end

        // Fill past full: the 17th write is rejected and pulses overflow once.
        cycle(0, 0, 1);
        for (int i = 0; i < 16; i++) cycle(1, 0, 0);
        chk("s3_full", 32'(full), 1);
        chk("s3_write_addr", 32'(write_addr), 0);
        chk("s3_level", 32'(level), 16);
        cycle(1, 0, 0);
        chk("s3_overflow", 32'(overflow), 1);
        chk("s3_level_hold", 32'(level), 16);
        cycle(0, 0, 0);
        chk("s3_overflow_clear", 32'(overflow), 0);
        for (int i = 0; i < 8; i++) cycle(0, 1, 0);
        chk("s3_full_after", 32'(full), 0);
        chk("s3_level_after", 32'(level), 12);

        // Full with the window on its last sample: read completes, write rejected.
        cycle(0, 0, 1);
        for (int i = 0; i < 16; i++) cycle(1, 0, 0);
        for (int i = 0; i < 7; i++) cycle(0, 1, 0);
        chk("s5_window_addr", 32'(window_addr), 7);
        chk("s5_win_last", 32'(win_last), 1);
        cycle(1, 1, 0);
        chk("s5_level", 32'(level), 12);
        chk("s5_overflow", 32'(overflow), 1);
        chk("s5_window_count", 32'(window_count), 1);
        chk("s5_read_addr", 32'(read_addr), 4);

        // Continuous stream, reset landing on sample 3 of window 10.
        cycle(0, 0, 1);
        for (int i = 0; i < 8; i++) cycle(1, 0, 0);
        for (int c = 0; c < 84; c++) begin
            cycle(1, 1, c == 83);
            if (c < 83) begin
                chk("s6_deq_fire", 32'(last_deq_fire), 1);
                chk("s6_read_addr", 32'(last_rd), (HOP * (c / WIN) + c % WIN) % DEPTH);
            end
        end
        for (int j = 0; j < 2; j++) begin
            chk("s6_empty", 32'(empty), 1);
            chk("s6_full", 32'(full), 0);
            chk("s6_level", 32'(level), 0);
            chk("s6_read_addr_rst", 32'(read_addr), 0);
            chk("s6_write_addr", 32'(write_addr), 0);
            chk("s6_win_first", 32'(win_first), 1);
            chk("s6_window_count", 32'(window_count), 0);
            chk("s6_pulses", 32'({overflow, underflow}), 0);
            cycle(0, 0, 0);
        end

        // Random traffic with alternating bias so both full and empty are visited.
        for (int c = 0; c < 3000; c++) begin
            bit e, d, r;
            int pe;
            pe = ((c / 400) % 2 == 0) ? 80 : 25;
            e = ($urandom_range(0, 99) < pe);
            d = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 599) == 0);
            cycle(e, d, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
